rtc_bus_arbiter: RTL and testbench

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

---
 rtl/rtc_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
// Shares the RTC serial bus between the periodic register-scan reader and the
// user time/date writer. Writes win by default. After a run of write grants
// taken while a read was waiting, one read is forced through.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; arbitrate when any request is high
// S_LATCH | owner granted, address/direction/data frozen
// S_START | one-cycle launch pulse to the protocol engine
// S_WAIT  | waiting for bus_done, timeout counter running
// S_DONE  | completion pulse to the owner, grant released
module rtc_bus_arbiter #(
    parameter logic [11:0] TIMEOUT    = 12'h04A,
    parameter int unsigned STARVE_LIM = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rd_req_i,
    input  logic [7:0] rd_addr_i,
    input  logic       wr_req_i,
    input  logic [7:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       bus_done_i,
    output logic       rd_gnt_o,
    output logic       wr_gnt_o,
    output logic       bus_start_o,
    output logic       bus_rw_o,
    output logic [7:0] bus_addr_o,
    output logic [7:0] bus_wdata_o,
    output logic       rd_done_o,
    output logic       wr_done_o,
    output logic       busy_o,
    output logic       timeout_err_o
);

    // Starvation counter is at least 2 bits and wide enough to hold STARVE_LIM.
    localparam int unsigned SW = ($clog2(STARVE_LIM + 1) > 2) ? $clog2(STARVE_LIM + 1) : 2;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            rd_gnt_q, rd_gnt_d;
    logic            wr_gnt_q, wr_gnt_d;
    logic            bus_rw_q, bus_rw_d;
    logic [7:0]      bus_addr_q, bus_addr_d;
    logic [7:0]      bus_wdata_q, bus_wdata_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [11:0]     tmo_q, tmo_d;
    logic            pick_rd;
    logic            tmo_hit;

    // Read wins only when the writer is idle or the reader has waited out the limit.
    assign pick_rd = rd_req_i && (!wr_req_i || (starve_q == STARVE_MAX));

    // A bus_done on the terminal count cycle still counts as success.
    assign tmo_hit = (tmo_q == TIMEOUT) && !bus_done_i;

    // State and datapath registers; reset parks the bus in read direction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            rd_gnt_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
            bus_rw_q    <= 1'b1;
            bus_addr_q  <= 8'h00;
            bus_wdata_q <= 8'h00;
            starve_q    <= '0;
            tmo_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            rd_gnt_q    <= rd_gnt_d;
            wr_gnt_q    <= wr_gnt_d;
            bus_rw_q    <= bus_rw_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state, arbitration, transaction capture and timeout counting.
    always_comb begin
        state_d     = state_q;
        rd_gnt_d    = rd_gnt_q;
        wr_gnt_d    = wr_gnt_q;
        bus_rw_d    = bus_rw_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;

        case (state_q)
            S_IDLE: begin
                tmo_d = 12'h000;
                if (rd_req_i || wr_req_i) begin
                    state_d     = S_LATCH;
                    rd_gnt_d    = pick_rd;
                    wr_gnt_d    = !pick_rd;
                    bus_rw_d    = pick_rd;
                    bus_addr_d  = pick_rd ? rd_addr_i : wr_addr_i;
                    bus_wdata_d = pick_rd ? 8'h00 : wr_data_i;
                    if (pick_rd) begin
                        starve_d = '0;
                    end else if (rd_req_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end

            S_LATCH: begin
                state_d = S_START;
            end

            S_START: begin
                state_d = S_WAIT;
                tmo_d   = 12'h000;
            end

            S_WAIT: begin
                if (bus_done_i) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d  = S_IDLE;
                    rd_gnt_d = 1'b0;
                    wr_gnt_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 12'd1;
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                rd_gnt_d = 1'b0;
                wr_gnt_d = 1'b0;
                tmo_d    = 12'h000;
            end

            default: begin
                state_d  = S_IDLE;
                rd_gnt_d = 1'b0;
                wr_gnt_d = 1'b0;
                tmo_d    = 12'h000;
            end
        endcase
    end

    assign rd_gnt_o      = rd_gnt_q;
    assign wr_gnt_o      = wr_gnt_q;
    assign bus_rw_o      = bus_rw_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign busy_o        = (state_q != S_IDLE);
    assign bus_start_o   = (state_q == S_START);
    assign rd_done_o     = (state_q == S_DONE) && rd_gnt_q;
    assign wr_done_o     = (state_q == S_DONE) && wr_gnt_q;
    assign timeout_err_o = (state_q == S_WAIT) && tmo_hit;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: expected transactions are queued as requests are
// raised; a monitor checks each launch and each completion/abort in order.
module tb_rtc_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_req, wr_req, bus_done;
    logic [7:0] rd_addr, wr_addr, wr_data;
    logic       rd_gnt_o, wr_gnt_o, bus_start_o, bus_rw_o;
    logic [7:0] bus_addr_o, bus_wdata_o;
    logic       rd_done_o, wr_done_o, busy_o, timeout_err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int k;

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rtc_bus_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_req_i     (rd_req),
        .rd_addr_i    (rd_addr),
        .wr_req_i     (wr_req),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .bus_done_i   (bus_done),
        .rd_gnt_o     (rd_gnt_o),
        .wr_gnt_o     (wr_gnt_o),
        .bus_start_o  (bus_start_o),
        .bus_rw_o     (bus_rw_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .rd_done_o    (rd_done_o),
        .wr_done_o    (wr_done_o),
        .busy_o       (busy_o),
        .timeout_err_o(timeout_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic rd, input logic [7:0] a, input logic [7:0] d,
                                input logic t);
        exp_t e;
        e.rd    = rd;
        e.addr  = a;
        e.wdata = d;
        e.tmo   = t;
        return e;
    endfunction

    // Wait (bounded) for the launch pulse; k = negedges taken.
    task automatic wait_start(output int kk);
        kk = 0;
        do begin
            @(negedge clk);
            kk++;
        end while (!bus_start_o && kk < 20);
        chk("start_seen", bus_start_o, 1);
    endtask

    // From the bus_start negedge: raise bus_done d negedges later for one cycle.
    task automatic finish_txn(input int d);
        repeat (d) @(negedge clk);
        bus_done = 1'b1;
        @(negedge clk);
        bus_done = 1'b0;
    endtask

    // Monitor: launches and completions checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n) begin
            chk("gnt_onehot", {31'd0, rd_gnt_o & wr_gnt_o}, 0);
            if (bus_start_o) begin
                chk("start_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    chk("start_rd_gnt", rd_gnt_o, e.rd);
                    chk("start_wr_gnt", wr_gnt_o, !e.rd);
                    chk("start_rw", bus_rw_o, e.rd);
                    chk("start_addr", bus_addr_o, e.addr);
                    chk("start_wdata", bus_wdata_o, e.wdata);
                end
            end
            if (rd_done_o || wr_done_o || timeout_err_o) begin
                chk("end_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (e.tmo)
                        chk("end_kind_tmo", {rd_done_o, wr_done_o, timeout_err_o}, 3'b001);
                    else
                        chk("end_kind_done", {rd_done_o, wr_done_o, timeout_err_o},
                            e.rd ? 3'b100 : 3'b010);
                    chk("end_addr_held", bus_addr_o, e.addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; bus_done = 1'b0;
        rd_addr = 8'h00; wr_addr = 8'h00; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_gnt", {rd_gnt_o, wr_gnt_o}, 0);
        chk("rst_rw", bus_rw_o, 1);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_start", bus_start_o, 0);
        rst_n = 1'b1;

        // Stray bus_done while idle
        @(negedge clk); bus_done = 1'b1;
        @(negedge clk); bus_done = 1'b0;
        chk("idle_done_busy", busy_o, 0);
        chk("idle_done_pulse", {rd_done_o, wr_done_o}, 0);

        // Single read, bus_done 5 cycles after start
        @(negedge clk);
        rd_addr = 8'h21; rd_req = 1'b1;
        sb.push_back(mk(1'b1, 8'h21, 8'h00, 1'b0));
        wait_start(k);
        chk("rd_latency", k, 2);
        finish_txn(5);
        chk("rd_done_pulse", rd_done_o, 1);
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_busy_fall", busy_o, 0);
        chk("rd_done_single", rd_done_o, 0);

        // Both requesting: write first, then read
        rd_addr = 8'h33; wr_addr = 8'h41; wr_data = 8'h59;
        rd_req = 1'b1; wr_req = 1'b1;
        sb.push_back(mk(1'b0, 8'h41, 8'h59, 1'b0));
        sb.push_back(mk(1'b1, 8'h33, 8'h00, 1'b0));
        wait_start(k);
        chk("wr_first_rw", bus_rw_o, 0);
        chk("wr_first_wdata", bus_wdata_o, 8'h59);
        finish_txn(2);
        chk("wr_done_pulse", wr_done_o, 1);
        wr_req = 1'b0;
        wait_start(k);
        chk("rd_after_wr_latency", k, 3);
        chk("rd_after_wr_gnt", rd_gnt_o, 1);
        finish_txn(1);
        rd_req = 1'b0;
        @(negedge clk);

        // Starvation: W,W,W,R,W with both held
        rd_addr = 8'h10; wr_addr = 8'h50; wr_data = 8'hA5;
        rd_req = 1'b1; wr_req = 1'b1;
        for (int i = 0; i < 5; i++)
            sb.push_back(mk(i == 3, (i == 3) ? 8'h10 : 8'h50, (i == 3) ? 8'h00 : 8'hA5, 1'b0));
        for (int i = 0; i < 5; i++) begin
            wait_start(k);
            finish_txn(1);
        end
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);

        // Write with no bus_done: timeout
        wr_addr = 8'h60; wr_data = 8'h77; wr_req = 1'b1;
        sb.push_back(mk(1'b0, 8'h60, 8'h77, 1'b1));
        wait_start(k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_err_o && k < 200);
        chk("tmo_latency", k - 1, 32'h4A);
        wr_req = 1'b0;
        @(negedge clk);
        chk("tmo_idle_next", busy_o, 0);
        chk("tmo_gnt_clear", wr_gnt_o, 0);
        chk("tmo_no_done", wr_done_o, 0);

        // bus_done on the terminal count cycle is a success
        rd_addr = 8'h0C; rd_req = 1'b1;
        sb.push_back(mk(1'b1, 8'h0C, 8'h00, 1'b0));
        wait_start(k);
        finish_txn(32'h4B);
        chk("edge_rd_done", rd_done_o, 1);
        rd_req = 1'b0;
        @(negedge clk);

        // Address held while requester changes/drops in flight
        rd_addr = 8'h22; rd_req = 1'b1;
        sb.push_back(mk(1'b1, 8'h22, 8'h00, 1'b0));
        wait_start(k);
        @(negedge clk);
        rd_addr = 8'h28; rd_req = 1'b0;
        @(negedge clk);
        chk("addr_hold", bus_addr_o, 8'h22);
        finish_txn(2);
        chk("drop_still_done", rd_done_o, 1);
        @(negedge clk);

        // Reset asserted during WAIT
        rd_addr = 8'h35; rd_req = 1'b1;
        sb.push_back(mk(1'b1, 8'h35, 8'h00, 1'b0));
        wait_start(k);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_gnt", {rd_gnt_o, wr_gnt_o}, 0);
        chk("rst_mid_rw", bus_rw_o, 1);
        chk("rst_mid_addr", bus_addr_o, 0);
        chk("rst_mid_start", bus_start_o, 0);
        rd_req = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); bus_done = 1'b1;
        @(negedge clk); bus_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_done", {rd_done_o, wr_done_o, busy_o}, 0);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
